// File: rtl/monitor_pkg.sv
// Shared slot type and small helpers for the commit-stream monitor.
package monitor_pkg;

    localparam int MAX_CHANNELS = 64;
    localparam int MAX_XLEN     = 64;

    typedef struct packed {
        logic [MAX_XLEN-1:0] pc;
        logic [MAX_XLEN-1:0] pc_next;
        logic                is_br;
    } commit_slot_t;

    function automatic int unsigned popcount(input logic [MAX_CHANNELS-1:0] bits);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_CHANNELS; i++) begin
            n += 32'(bits[i]);
        end
        return n;
    endfunction

    // Branch-to-self: the halt idiom used by the test programs.
    function automatic logic self_loop(input logic [MAX_XLEN-1:0] pc,
                                       input logic [MAX_XLEN-1:0] pc_next,
                                       input logic                is_br);
        return is_br && (pc_next == pc);
    endfunction

endpackage

// File: rtl/commit_trace_ring.sv
// Circular history of the most recently committed PCs, newest-relative readout.
module commit_trace_ring
    import monitor_pkg::*;
#(
    parameter  int XLEN     = 32,
    parameter  int DEPTH    = 8,
    parameter  int CHANNELS = 1,
    localparam int IDX_W    = $clog2(DEPTH),
    localparam int FILL_W   = IDX_W + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [CHANNELS-1:0]      wr_en,
    input  logic [CHANNELS*XLEN-1:0] wr_pc,
    input  logic [IDX_W-1:0]         rd_idx,
    output logic [XLEN-1:0]          rd_pc,
    output logic [FILL_W-1:0]        fill
);

    logic [XLEN-1:0]   mem_q [DEPTH];
    logic [XLEN-1:0]   mem_d [DEPTH];
    logic [IDX_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [IDX_W-1:0]  rd_addr;
    int unsigned       fill_sum;

    // Later slots overwrite earlier ones, so with CHANNELS > DEPTH the youngest survive.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (wr_en[i]) begin
                mem_d[wr_ptr_d] = wr_pc[i*XLEN +: XLEN];
                wr_ptr_d        = wr_ptr_d + IDX_W'(1);
            end
        end
        fill_sum = 32'(fill_q) + popcount(MAX_CHANNELS'(wr_en));
        fill_d   = (fill_sum >= unsigned'(DEPTH)) ? FILL_W'(DEPTH) : FILL_W'(fill_sum);
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                mem_q[gi] <= '0;
            end else begin
                mem_q[gi] <= mem_d[gi];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
        end
    end

    assign rd_addr = wr_ptr_q - IDX_W'(1) - rd_idx;
    assign rd_pc   = ({1'b0, rd_idx} < fill_q) ? mem_q[rd_addr] : '0;
    assign fill    = fill_q;

endmodule

// File: rtl/commit_monitor.sv
// Retirement monitor: order numbering, self-loop halt detection, idle watchdog
// and a trace of recent commit PCs.
module commit_monitor
    import monitor_pkg::*;
#(
    parameter int CHANNELS       = 1,
    parameter int XLEN           = 32,
    parameter int ORDER_W        = 64,
    parameter int HALT_REPEAT    = 2,
    parameter int TIMEOUT_CYCLES = 100000000,
    parameter int TRACE_DEPTH    = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [CHANNELS-1:0]           commit_valid,
    input  logic [CHANNELS*XLEN-1:0]      commit_pc,
    input  logic [CHANNELS*XLEN-1:0]      commit_pc_next,
    input  logic [CHANNELS-1:0]           commit_is_br,
    output logic [CHANNELS*ORDER_W-1:0]   commit_order,
    output logic [ORDER_W-1:0]            order,
    output logic                          halt,
    output logic                          timeout,
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
    output logic [XLEN-1:0]               trace_pc,
    output logic [$clog2(TRACE_DEPTH):0]  trace_fill
);

    localparam int LOOP_W = $clog2(HALT_REPEAT + 1);
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [ORDER_W-1:0]  order_q, order_d, run_order;
    logic                halt_q, halt_d;
    logic                timeout_q, timeout_d;
    logic [LOOP_W-1:0]   loop_cnt_q, loop_cnt_d;
    logic [XLEN-1:0]     loop_pc_q, loop_pc_d;
    logic [IDLE_W-1:0]   idle_q, idle_d, idle_inc;
    logic [CHANNELS-1:0] accepted;
    logic                frozen;
    logic                halt_hit;
    commit_slot_t        slot;

    assign frozen   = halt_q | timeout_q;
    assign accepted = commit_valid & {CHANNELS{~frozen}};
    assign idle_inc = idle_q + IDLE_W'(1);

    // Slots are walked oldest-first so the loop counter sees program order.
    always_comb begin
        run_order    = order_q;
        loop_cnt_d   = loop_cnt_q;
        loop_pc_d    = loop_pc_q;
        halt_hit     = 1'b0;
        slot         = '0;
        commit_order = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            commit_order[i*ORDER_W +: ORDER_W] = run_order;
            slot.pc      = MAX_XLEN'(commit_pc[i*XLEN +: XLEN]);
            slot.pc_next = MAX_XLEN'(commit_pc_next[i*XLEN +: XLEN]);
            slot.is_br   = commit_is_br[i];
            if (accepted[i]) begin
                run_order = run_order + ORDER_W'(1);
                if (self_loop(slot.pc, slot.pc_next, slot.is_br)) begin
                    if (commit_pc[i*XLEN +: XLEN] == loop_pc_d) begin
                        if (loop_cnt_d != LOOP_W'(HALT_REPEAT)) begin
                            loop_cnt_d = loop_cnt_d + LOOP_W'(1);
                        end
                    end else begin
                        loop_cnt_d = LOOP_W'(1);
                        loop_pc_d  = commit_pc[i*XLEN +: XLEN];
                    end
                    if (loop_cnt_d == LOOP_W'(HALT_REPEAT)) begin
                        halt_hit = 1'b1;
                    end
                end else begin
                    loop_cnt_d = '0;
                end
            end
        end
        order_d = run_order;
    end

    // A halting cycle always has an accepted slot, so it can never also time out.
    always_comb begin
        idle_d    = idle_q;
        timeout_d = timeout_q;
        halt_d    = halt_q | halt_hit;
        if (!frozen) begin
            if (|accepted) begin
                idle_d = '0;
            end else begin
                idle_d = idle_inc;
                if (idle_inc == IDLE_W'(TIMEOUT_CYCLES)) begin
                    timeout_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            order_q    <= '0;
            halt_q     <= 1'b0;
            timeout_q  <= 1'b0;
            loop_cnt_q <= '0;
            loop_pc_q  <= '0;
            idle_q     <= '0;
        end else begin
            order_q    <= order_d;
            halt_q     <= halt_d;
            timeout_q  <= timeout_d;
            loop_cnt_q <= loop_cnt_d;
            loop_pc_q  <= loop_pc_d;
            idle_q     <= idle_d;
        end
    end

    assign order   = order_q;
    assign halt    = halt_q;
    assign timeout = timeout_q;

    commit_trace_ring #(
        .XLEN     (XLEN),
        .DEPTH    (TRACE_DEPTH),
        .CHANNELS (CHANNELS)
    ) u_trace (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (accepted),
        .wr_pc  (commit_pc),
        .rd_idx (trace_idx),
        .rd_pc  (trace_pc),
        .fill   (trace_fill)
    );

endmodule

// File: tb/tb_commit_monitor.sv
// Bench for commit_monitor: a 1-slot and a 2-slot instance checked every cycle
// against a queue/history model, plus directed literal expectations.
module tb_commit_monitor;

    localparam int HR  = 2;
    localparam int TO  = 10;
    localparam int DEP = 4;

    logic clk;
    logic rst_n;

    logic         a_valid, a_br;
    logic [31:0]  a_pc, a_pcn;
    logic [63:0]  a_co, a_order;
    logic         a_halt, a_to;
    logic [1:0]   a_idx;
    logic [31:0]  a_tpc;
    logic [2:0]   a_fill;

    logic [1:0]   b_valid, b_br;
    logic [63:0]  b_pc, b_pcn;
    logic [127:0] b_co;
    logic [63:0]  b_order;
    logic         b_halt, b_to;
    logic [1:0]   b_idx;
    logic [31:0]  b_tpc;
    logic [2:0]   b_fill;

    int total = 0;
    int bad   = 0;

    commit_monitor #(
        .CHANNELS(1), .XLEN(32), .ORDER_W(64), .HALT_REPEAT(HR),
        .TIMEOUT_CYCLES(TO), .TRACE_DEPTH(DEP)
    ) dut_a (
        .clk(clk), .reset(rst_n),
        .commit_valid(a_valid), .commit_pc(a_pc), .commit_pc_next(a_pcn),
        .commit_is_br(a_br), .commit_order(a_co), .order(a_order),
        .halt(a_halt), .timeout(a_to), .trace_idx(a_idx),
        .trace_pc(a_tpc), .trace_fill(a_fill)
    );

    commit_monitor #(
        .CHANNELS(2), .XLEN(32), .ORDER_W(64), .HALT_REPEAT(HR),
        .TIMEOUT_CYCLES(TO), .TRACE_DEPTH(DEP)
    ) dut_b (
        .clk(clk), .reset(rst_n),
        .commit_valid(b_valid), .commit_pc(b_pc), .commit_pc_next(b_pcn),
        .commit_is_br(b_br), .commit_order(b_co), .order(b_order),
        .halt(b_halt), .timeout(b_to), .trace_idx(b_idx),
        .trace_pc(b_tpc), .trace_fill(b_fill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [63:0] m_order   [2];
    bit          m_halt    [2];
    bit          m_to      [2];
    int          m_idle    [2];
    int          m_loop    [2];
    logic [31:0] m_loop_pc [2];
    logic [31:0] m_hist    [2][DEP];   // index 0 = newest
    int          m_fill    [2];

    task automatic model_reset(input int d);
        m_order[d] = '0; m_halt[d] = 0; m_to[d] = 0; m_idle[d] = 0;
        m_loop[d] = 0; m_loop_pc[d] = '0; m_fill[d] = 0;
        for (int k = 0; k < DEP; k++) m_hist[d][k] = '0;
    endtask

    task automatic model_step(input int d, input int ch, input logic [1:0] v,
                              input logic [63:0] pc, input logic [63:0] pcn,
                              input logic [1:0] br);
        int  n;
        bit  halt_now;
        logic [31:0] p;
        n = 0;
        halt_now = 0;
        if (m_halt[d] || m_to[d]) return;
        for (int i = 0; i < ch; i++) begin
            if (v[i]) begin
                p = pc[i*32 +: 32];
                n++;
                for (int k = DEP - 1; k > 0; k--) m_hist[d][k] = m_hist[d][k-1];
                m_hist[d][0] = p;
                if (m_fill[d] < DEP) m_fill[d]++;
                if (br[i] && pcn[i*32 +: 32] == p) begin
                    if (m_loop[d] > 0 && m_loop_pc[d] == p) begin
                        if (m_loop[d] < HR) m_loop[d]++;
                    end else begin
                        m_loop[d] = 1;
                        m_loop_pc[d] = p;
                    end
                    if (m_loop[d] == HR) halt_now = 1;
                end else begin
                    m_loop[d] = 0;
                end
            end
        end
        m_order[d] = m_order[d] + 64'(n);
        if (n == 0) begin
            m_idle[d]++;
            if (m_idle[d] == TO) m_to[d] = 1;
        end else begin
            m_idle[d] = 0;
        end
        if (halt_now) m_halt[d] = 1;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset(0);
            model_reset(1);
        end else begin
            model_step(0, 1, {1'b0, a_valid}, {32'b0, a_pc}, {32'b0, a_pcn}, {1'b0, a_br});
            model_step(1, 2, b_valid, b_pc, b_pcn, b_br);
        end
    end

    task automatic cmp_dut(input int d, input int ch, input logic [1:0] v,
                           input logic [127:0] co, input logic [63:0] ord,
                           input logic h, input logic t, input logic [1:0] idx,
                           input logic [31:0] tpc, input logic [2:0] fill);
        logic [63:0] run;
        logic [31:0] exp_tpc;
        run = m_order[d];
        for (int i = 0; i < ch; i++) begin
            if (v[i] && !(m_halt[d] || m_to[d])) begin
                chk($sformatf("dut%0d commit_order[%0d]", d, i), co[i*64 +: 64], run);
                run = run + 64'd1;
            end
        end
        chk($sformatf("dut%0d order", d), ord, m_order[d]);
        chk($sformatf("dut%0d halt", d), 64'(h), 64'(m_halt[d]));
        chk($sformatf("dut%0d timeout", d), 64'(t), 64'(m_to[d]));
        chk($sformatf("dut%0d trace_fill", d), 64'(fill), 64'(m_fill[d]));
        exp_tpc = (int'(idx) < m_fill[d]) ? m_hist[d][idx] : 32'h0;
        chk($sformatf("dut%0d trace_pc[%0d]", d, idx), 64'(tpc), 64'(exp_tpc));
    endtask

    always @(negedge clk) begin
        cmp_dut(0, 1, {1'b0, a_valid}, {64'b0, a_co}, a_order, a_halt, a_to, a_idx, a_tpc, a_fill);
        cmp_dut(1, 2, b_valid, b_co, b_order, b_halt, b_to, b_idx, b_tpc, b_fill);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic set_a(input logic v, input logic [31:0] pc, input logic [31:0] pcn, input logic br);
        a_valid = v; a_pc = pc; a_pcn = pcn; a_br = br;
        if (v) $display("tx A pc=%08h next=%08h br=%0b", pc, pcn, br);
    endtask

    task automatic set_b(input logic [1:0] v, input logic [63:0] pc, input logic [63:0] pcn, input logic [1:0] br);
        b_valid = v; b_pc = pc; b_pcn = pcn; b_br = br;
        if (v != 2'b00) $display("tx B valid=%02b pc=%016h next=%016h br=%02b", v, pc, pcn, br);
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        a_idx = '0; b_idx = '0;
        set_a(1'b0, '0, '0, 1'b0);
        set_b(2'b00, '0, '0, 2'b00);
        tick;
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset;
        // Outputs straight out of reset
        chk("reset order A", a_order, 0);
        chk("reset halt A", 64'(a_halt), 0);
        chk("reset timeout A", 64'(a_to), 0);
        chk("reset fill A", 64'(a_fill), 0);
        chk("reset trace_pc A", 64'(a_tpc), 0);
        chk("reset order B", b_order, 0);

        // Single-slot in-order commits
        set_a(1'b1, 32'h60, 32'h64, 1'b0); #1 chk("t1 commit_order 0", a_co, 0); tick;
        set_a(1'b1, 32'h64, 32'h68, 1'b0); #1 chk("t1 commit_order 1", a_co, 1); tick;
        set_a(1'b1, 32'h68, 32'h6c, 1'b0); #1 chk("t1 commit_order 2", a_co, 2); tick;
        set_a(1'b0, '0, '0, 1'b0);
        #1;
        chk("t1 order", a_order, 3);
        chk("t1 fill", 64'(a_fill), 3);
        chk("t1 trace idx0", 64'(a_tpc), 64'h68);
        a_idx = 2'd2; #1 chk("t1 trace idx2", 64'(a_tpc), 64'h60);
        tick;
        a_idx = 2'd3; #1 chk("t1 trace idx3 beyond fill", 64'(a_tpc), 0);

        // Two-slot, non-contiguous then full
        do_reset;
        set_b(2'b10, {32'h100, 32'h0}, {32'h104, 32'h0}, 2'b00);
        #1 chk("t2 commit_order[1] first", b_co[127:64], 0);
        tick;
        set_b(2'b11, {32'h108, 32'h104}, {32'h10c, 32'h108}, 2'b00);
        #1;
        chk("t2 order after first", b_order, 1);
        chk("t2 commit_order[0]", b_co[63:0], 1);
        chk("t2 commit_order[1]", b_co[127:64], 2);
        tick;
        set_b(2'b00, '0, '0, 2'b00);
        #1;
        chk("t2 order", b_order, 3);
        chk("t2 trace newest", 64'(b_tpc), 64'h108);

        // Two self-loops in one cycle: both counted, halt next cycle
        do_reset;
        set_b(2'b11, {32'h200, 32'h200}, {32'h200, 32'h200}, 2'b11);
        #1 chk("t2b halt before edge", 64'(b_halt), 0);
        tick;
        set_b(2'b01, {32'h0, 32'h300}, {32'h0, 32'h304}, 2'b00);
        #1;
        chk("t2b halt", 64'(b_halt), 1);
        chk("t2b order", b_order, 2);
        chk("t2b fill", 64'(b_fill), 2);
        tick;
        chk("t2b order frozen", b_order, 2);

        // Halt after two consecutive self-loops
        do_reset;
        set_a(1'b1, 32'h80, 32'h80, 1'b1);
        tick; chk("t3 halt after one", 64'(a_halt), 0);
        tick; chk("t3 halt after two", 64'(a_halt), 1);
        chk("t3 order", a_order, 2);
        set_a(1'b1, 32'h84, 32'h88, 1'b0);
        tick; chk("t3 order frozen", a_order, 2);
        chk("t3 trace frozen", 64'(a_tpc), 64'h80);

        // Non-loop in between restarts the count
        do_reset;
        set_a(1'b1, 32'h80, 32'h80, 1'b1); tick;
        set_a(1'b1, 32'h84, 32'h88, 1'b0); tick;
        set_a(1'b1, 32'h80, 32'h80, 1'b1); tick;
        chk("t4 halt after restart", 64'(a_halt), 0);
        tick;
        chk("t4 halt", 64'(a_halt), 1);
        chk("t4 order", a_order, 4);

        // Watchdog
        do_reset;
        repeat (9) tick;
        chk("t5 timeout at 9", 64'(a_to), 0);
        tick;
        chk("t5 timeout at 10", 64'(a_to), 1);
        do_reset;
        repeat (4) tick;
        set_a(1'b1, 32'h40, 32'h44, 1'b0); tick;
        set_a(1'b0, '0, '0, 1'b0);
        repeat (9) tick;
        chk("t5 timeout at 14", 64'(a_to), 0);
        tick;
        chk("t5 timeout at 15", 64'(a_to), 1);
        set_a(1'b1, 32'h50, 32'h54, 1'b0); tick;
        chk("t5 order frozen", a_order, 1);
        rst_n = 1'b0;
        #1 chk("t5 timeout cleared by reset", 64'(a_to), 0);
        set_a(1'b0, '0, '0, 1'b0);
        tick;
        rst_n = 1'b1;

        // Trace wrap and mid-stream reset
        do_reset;
        for (int k = 0; k < 6; k++) begin
            set_a(1'b1, 32'(k * 4), 32'(k * 4 + 4), 1'b0);
            tick;
        end
        set_a(1'b0, '0, '0, 1'b0);
        a_idx = 2'd3;
        #1;
        chk("t6 fill", 64'(a_fill), 4);
        chk("t6 trace idx3", 64'(a_tpc), 64'h08);
        a_idx = 2'd0;
        #1 chk("t6 trace idx0", 64'(a_tpc), 64'h14);
        set_a(1'b1, 32'h18, 32'h1c, 1'b0);
        tick;
        rst_n = 1'b0;
        #1;
        chk("t6 async order", a_order, 0);
        chk("t6 async fill", 64'(a_fill), 0);
        chk("t6 async trace", 64'(a_tpc), 0);
        tick;
        rst_n = 1'b1;
        set_a(1'b1, 32'h20, 32'h24, 1'b0);
        #1 chk("t6 first after reset commit_order", a_co, 0);
        tick;
        set_a(1'b0, '0, '0, 1'b0);
        #1;
        chk("t6 order after reset", a_order, 1);
        chk("t6 fill after reset", 64'(a_fill), 1);
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
